rf68000_ea_ext_fetch: RTL and testbench

Effective-address extension-word reader for the rf68000 decode stage. Given an EA mode/register/size, it consumes the 0, 1 or 2 extension words the EA requires from the instruction-word stream. It assembles them into a 32-bit extension value plus brief-format index fields, and reports the updated PC. It sits between the instruction fetch queue and the EA calculation logic, and consumes exactly the word count defined by the package's extension-length table.

---
 rtl/rf68000_ea_ext_fetch.sv | 193 +++++++++++++++++++
 tb/tb_rf68000_ea_ext_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf68000_ea_ext_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf68000_ea_ext_fetch
// Purpose  : Reads the 0-2 EA extension words from the fetch queue and
//            assembles the extension value, brief index fields and next PC.
// Revision : 1.0  initial release
// ============================================================================
module rf68000_ea_ext_fetch (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  sz_i,
    input  logic [2:0]  mode_i,
    input  logic [2:0]  reg_i,
    input  logic [31:0] pc_i,
    input  logic        abort_i,
    input  logic        fw_valid_i,
    input  logic [15:0] fw_data_i,
    output logic        fw_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] ext_o,
    output logic [3:0]  xreg_o,
    output logic        xlong_o,
    output logic [1:0]  nwords_o,
    output logic [31:0] next_pc_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [1:0]  sz_q;
    logic [2:0]  mode_q;
    logic [2:0]  reg_q;
    logic [31:0] pc_q;
    logic [15:0] w0_q;

    logic [1:0]  cur_sz;
    logic [2:0]  cur_mode;
    logic [2:0]  cur_reg;
    logic [31:0] cur_pc;
    logic [1:0]  cur_n;
    logic [15:0] word0;
    logic [15:0] word1;
    logic        handshake;
    logic        finish;
    logic        cur_illegal;
    logic [31:0] asm_ext;
    logic [3:0]  asm_xreg;
    logic        asm_xlong;

    function automatic logic [1:0] word_count(input logic [2:0] mode,
                                              input logic [2:0] rg,
                                              input logic [1:0] sz);
        logic [1:0] n;
        n = 2'd0;
        case (mode)
            3'd5, 3'd6: n = 2'd1;
            3'd7: begin
                case (rg)
                    3'd0, 3'd2, 3'd3: n = 2'd1;
                    3'd1:             n = 2'd2;
                    3'd4:             n = (sz == 2'd2) ? 2'd2 : 2'd1;
                    default:          n = 2'd0;
                endcase
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // In IDLE the live request fields decide the path; afterwards the captured copy does.
    assign cur_sz    = (state == IDLE) ? sz_i   : sz_q;
    assign cur_mode  = (state == IDLE) ? mode_i : mode_q;
    assign cur_reg   = (state == IDLE) ? reg_i  : reg_q;
    assign cur_pc    = (state == IDLE) ? pc_i   : pc_q;
    assign cur_n     = word_count(cur_mode, cur_reg, cur_sz);
    assign cur_illegal = (cur_mode == 3'd7) && (cur_reg >= 3'd5);

    assign word0     = (state == W0) ? fw_data_i : w0_q;
    assign word1     = fw_data_i;

    assign fw_ready_o = ((state == W0) || (state == W1)) && !abort_i;
    assign handshake  = fw_ready_o && fw_valid_i;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

    always_comb begin
        asm_ext   = 32'd0;
        asm_xreg  = 4'd0;
        asm_xlong = 1'b0;
        case (cur_mode)
            3'd5: asm_ext = {{16{word0[15]}}, word0};
            3'd6: begin
                asm_ext   = {{24{word0[7]}}, word0[7:0]};
                asm_xreg  = word0[15:12];
                asm_xlong = word0[11];
            end
            3'd7: begin
                case (cur_reg)
                    3'd0, 3'd2: asm_ext = {{16{word0[15]}}, word0};
                    3'd3: begin
                        asm_ext   = {{24{word0[7]}}, word0[7:0]};
                        asm_xreg  = word0[15:12];
                        asm_xlong = word0[11];
                    end
                    3'd1: asm_ext = {word0, word1};
                    3'd4: begin
                        case (cur_sz)
                            2'd0:    asm_ext = {24'd0, word0[7:0]};
                            2'd2:    asm_ext = {word0, word1};
                            default: asm_ext = {16'd0, word0};
                        endcase
                    end
                    default: asm_ext = 32'd0;
                endcase
            end
            default: asm_ext = 32'd0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (!abort_i && req_i)
                    state_n = (cur_n != 2'd0) ? W0 : DONE;
            end
            W0: begin
                if (abort_i)
                    state_n = IDLE;
                else if (fw_valid_i)
                    state_n = (cur_n == 2'd2) ? W1 : DONE;
            end
            W1: begin
                if (abort_i)
                    state_n = IDLE;
                else if (fw_valid_i)
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign finish = (state_n == DONE) && (state != DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sz_q      <= 2'd0;
            mode_q    <= 3'd0;
            reg_q     <= 3'd0;
            pc_q      <= 32'd0;
            w0_q      <= 16'd0;
            ext_o     <= 32'd0;
            xreg_o    <= 4'd0;
            xlong_o   <= 1'b0;
            nwords_o  <= 2'd0;
            next_pc_o <= 32'd0;
            illegal_o <= 1'b0;
        end else begin
            state <= state_n;
            if ((state == IDLE) && req_i && !abort_i) begin
                sz_q   <= sz_i;
                mode_q <= mode_i;
                reg_q  <= reg_i;
                pc_q   <= pc_i;
            end
            if ((state == W0) && handshake)
                w0_q <= fw_data_i;
            // Results are latched once on entry to DONE and held until the next request completes.
            if (finish) begin
                ext_o     <= asm_ext;
                xreg_o    <= asm_xreg;
                xlong_o   <= asm_xlong;
                nwords_o  <= cur_n;
                next_pc_o <= cur_pc + {29'd0, cur_n, 1'b0};
                illegal_o <= cur_illegal;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf68000_ea_ext_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf68000_ea_ext_fetch
// Purpose  : Table-driven, scoreboarded bench for the EA extension reader.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf68000_ea_ext_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  sz;
    logic [2:0]  mode;
    logic [2:0]  rg;
    logic [31:0] pc;
    logic        abort;
    logic        fw_valid;
    logic [15:0] fw_data;
    logic        fw_ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] ext_o;
    logic [3:0]  xreg_o;
    logic        xlong_o;
    logic [1:0]  nwords_o;
    logic [31:0] next_pc_o;
    logic        illegal_o;

    rf68000_ea_ext_fetch dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .sz_i       (sz),
        .mode_i     (mode),
        .reg_i      (rg),
        .pc_i       (pc),
        .abort_i    (abort),
        .fw_valid_i (fw_valid),
        .fw_data_i  (fw_data),
        .fw_ready_o (fw_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ext_o      (ext_o),
        .xreg_o     (xreg_o),
        .xlong_o    (xlong_o),
        .nwords_o   (nwords_o),
        .next_pc_o  (next_pc_o),
        .illegal_o  (illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [2:0]  rg;
        logic [1:0]  sz;
        logic [31:0] pc;
        logic [15:0] w0;
        logic [15:0] w1;
        int          gap;
        logic [31:0] ext;
        logic [3:0]  xreg;
        logic        xlong;
        logic [1:0]  n;
        logic        illegal;
    } vec_t;

    typedef struct {
        logic [31:0] ext;
        logic [3:0]  xreg;
        logic        xlong;
        logic [1:0]  n;
        logic [31:0] next_pc;
        logic        illegal;
        int          lat;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    logic [31:0] last_ext;
    logic [1:0]  last_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_fw_ready"}, 32'(fw_ready_o), 32'd0);
        check({tag, "_busy"},     32'(busy_o),     32'd0);
        check({tag, "_done"},     32'(done_o),     32'd0);
        check({tag, "_ext"},      ext_o,           32'd0);
        check({tag, "_xreg"},     32'(xreg_o),     32'd0);
        check({tag, "_xlong"},    32'(xlong_o),    32'd0);
        check({tag, "_nwords"},   32'(nwords_o),   32'd0);
        check({tag, "_next_pc"},  next_pc_o,       32'd0);
        check({tag, "_illegal"},  32'(illegal_o),  32'd0);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t        e;
        logic [15:0] words[2];
        int          wi;
        int          gc;
        bit          seen;
        e.ext     = v.ext;
        e.xreg    = v.xreg;
        e.xlong   = v.xlong;
        e.n       = v.n;
        e.next_pc = v.pc + 32'(2 * int'(v.n));
        e.illegal = v.illegal;
        e.lat     = (v.n == 2'd0) ? 1 : (v.n == 2'd1) ? 2 : 3 + v.gap;
        sb.push_back(e);
        words[0] = v.w0;
        words[1] = v.w1;
        wi = 0;
        gc = 0;
        seen = 1'b0;
        @(negedge clk);
        req  = 1'b1;
        mode = v.mode;
        rg   = v.rg;
        sz   = v.sz;
        pc   = v.pc;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", 32'(k),         32'(e.lat));
                    check("ext",     ext_o,          e.ext);
                    check("xreg",    32'(xreg_o),    32'(e.xreg));
                    check("xlong",   32'(xlong_o),   32'(e.xlong));
                    check("nwords",  32'(nwords_o),  32'(e.n));
                    check("next_pc", next_pc_o,      e.next_pc);
                    check("illegal", 32'(illegal_o), 32'(e.illegal));
                end
                break;
            end
            fw_valid = 1'b0;
            if (wi < int'(v.n)) begin
                if (wi == 1 && gc < v.gap) gc++;
                else begin
                    fw_valid = 1'b1;
                    fw_data  = words[wi];
                end
            end
            #1;
            if (fw_valid && fw_ready_o) wi++;
        end
        fw_valid = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("words_consumed", 32'(wi), 32'(v.n));
        last_ext = v.ext;
        last_n   = v.n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 1'b0; sz = 2'd0; mode = 3'd0; rg = 3'd0; pc = 32'd0;
        abort = 1'b0; fw_valid = 1'b0; fw_data = 16'd0;
        last_ext = 32'd0; last_n = 2'd0;
        rst = 1'b1;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //           mode  reg   sz    pc             w0        w1        gap ext              xreg  xl    n     ill
        vecs[0]  = '{3'd5, 3'd3, 2'd1, 32'h0000_1000, 16'hFFFE, 16'h0000, 0, 32'hFFFF_FFFE, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[1]  = '{3'd7, 3'd1, 2'd1, 32'h0000_2000, 16'h1234, 16'h5678, 2, 32'h1234_5678, 4'h0, 1'b0, 2'd2, 1'b0};
        vecs[2]  = '{3'd6, 3'd2, 2'd1, 32'h0000_3000, 16'hA880, 16'h0000, 0, 32'hFFFF_FF80, 4'hA, 1'b1, 2'd1, 1'b0};
        vecs[3]  = '{3'd7, 3'd4, 2'd0, 32'h0000_3100, 16'hFF85, 16'h0000, 0, 32'h0000_0085, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[4]  = '{3'd7, 3'd6, 2'd1, 32'h0000_3200, 16'h0000, 16'h0000, 0, 32'h0000_0000, 4'h0, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{3'd0, 3'd0, 2'd2, 32'h0000_3300, 16'h0000, 16'h0000, 0, 32'h0000_0000, 4'h0, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{3'd7, 3'd4, 2'd2, 32'h0000_3400, 16'hABCD, 16'h0123, 0, 32'hABCD_0123, 4'h0, 1'b0, 2'd2, 1'b0};
        vecs[7]  = '{3'd7, 3'd4, 2'd3, 32'h0000_3500, 16'h8001, 16'h0000, 0, 32'h0000_8001, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[8]  = '{3'd7, 3'd4, 2'd1, 32'h0000_3600, 16'hC001, 16'h0000, 0, 32'h0000_C001, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[9]  = '{3'd7, 3'd0, 2'd1, 32'h0000_3700, 16'h8000, 16'h0000, 0, 32'hFFFF_8000, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{3'd7, 3'd3, 2'd1, 32'hFFFF_FFFE, 16'h377F, 16'h0000, 1, 32'h0000_007F, 4'h3, 1'b0, 2'd1, 1'b0};
        vecs[11] = '{3'd7, 3'd2, 2'd1, 32'h0000_3900, 16'h0010, 16'h0000, 0, 32'h0000_0010, 4'h0, 1'b0, 2'd1, 1'b0};
        vecs[12] = '{3'd7, 3'd5, 2'd2, 32'h0000_3A00, 16'h0000, 16'h0000, 0, 32'h0000_0000, 4'h0, 1'b0, 2'd0, 1'b1};
        vecs[13] = '{3'd4, 3'd7, 2'd1, 32'h0000_3B00, 16'h0000, 16'h0000, 0, 32'h0000_0000, 4'h0, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < NVEC; i++) run_txn(vecs[i]);

        // Abort while waiting for the second abs32 word.
        @(negedge clk);
        req = 1'b1; mode = 3'd7; rg = 3'd1; sz = 2'd1; pc = 32'h0000_4000;
        @(negedge clk);
        req = 1'b0; fw_valid = 1'b1; fw_data = 16'h1111;
        @(negedge clk);
        abort = 1'b1; fw_valid = 1'b1; fw_data = 16'h2222;
        #1;
        check("abort_fw_ready", 32'(fw_ready_o), 32'd0);
        check("abort_busy_in_w1", 32'(busy_o), 32'd1);
        @(negedge clk);
        abort = 1'b0; fw_valid = 1'b0;
        check("abort_idle", 32'(busy_o), 32'd0);
        check("abort_no_done", 32'(done_o), 32'd0);
        check("abort_ext_held", ext_o, last_ext);
        check("abort_nwords_held", 32'(nwords_o), 32'(last_n));
        @(negedge clk);
        check("abort_no_late_done", 32'(done_o), 32'd0);
        run_txn(vecs[0]);

        // Asynchronous reset in the middle of W0.
        @(negedge clk);
        req = 1'b1; mode = 3'd5; rg = 3'd0; sz = 2'd1; pc = 32'h0000_5000;
        @(negedge clk);
        req = 1'b0; fw_valid = 1'b0;
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;

        // A request raised while busy must not start a second fetch.
        @(negedge clk);
        req = 1'b1; mode = 3'd5; rg = 3'd0; sz = 2'd1; pc = 32'h0000_6000;
        @(negedge clk);
        req = 1'b1; mode = 3'd7; rg = 3'd1; pc = 32'h0000_7000;
        fw_valid = 1'b1; fw_data = 16'h0042;
        @(negedge clk);
        fw_valid = 1'b0;
        check("busyreq_done", 32'(done_o), 32'd1);
        check("busyreq_nwords", 32'(nwords_o), 32'd1);
        check("busyreq_ext", ext_o, 32'h0000_0042);
        check("busyreq_next_pc", next_pc_o, 32'h0000_6002);
        req = 1'b0;
        @(negedge clk);
        check("busyreq_not_queued", 32'(busy_o), 32'd0);
        check("busyreq_single_done", 32'(done_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
